// File: rtl/hv_sram_read_arbiter.sv
// Round-robin read arbiter sharing one fixed-latency HV SRAM bank among NUM_REQ requesters,
// with credit-protected in-order response FIFO. Optional perf counters via `SRAM_ARB_PERF_EN.

`ifndef HV_DIMENSION
`define HV_DIMENSION 256
`endif

module hv_sram_read_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = `HV_DIMENSION,
    parameter int READ_LATENCY = 1,
    parameter int RESP_DEPTH   = READ_LATENCY + 1
) (
    input  logic                          Clk_CI,
    input  logic                          Reset_RI,
    input  logic [NUM_REQ-1:0]            Req_SI,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] Addr_DI,
    output logic [NUM_REQ-1:0]            Gnt_SO,
    output logic [NUM_REQ-1:0]            RdValid_SO,
    input  logic [NUM_REQ-1:0]            RdReady_SI,
    output logic [DATA_WIDTH-1:0]         RdData_DO,
`ifdef SRAM_ARB_PERF_EN
    output logic [NUM_REQ*16-1:0]         PerfGnt_DO,
    output logic [NUM_REQ*16-1:0]         PerfStall_DO,
`endif
    output logic                          SramEn_SO,
    output logic [ADDR_WIDTH-1:0]         SramAddr_DO,
    input  logic [DATA_WIDTH-1:0]         SramData_DI
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W   = $clog2(RESP_DEPTH + 1);
    localparam int FIFO_AW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    localparam logic [PTR_W-1:0]   LAST_REQ  = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(RESP_DEPTH);
    localparam logic [FIFO_AW-1:0] LAST_SLOT = FIFO_AW'(RESP_DEPTH - 1);

    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   credit_cnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic               issue_ok;
    logic               pop;
    logic               push;
    int                 arb_idx;

    logic [READ_LATENCY-1:0] pipe_vld;
    logic [PTR_W-1:0]        pipe_tag [READ_LATENCY];

    logic [DATA_WIDTH-1:0] fifo_data [RESP_DEPTH];
    logic [PTR_W-1:0]      fifo_tag  [RESP_DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic                  fifo_empty;
    logic [PTR_W-1:0]      head_tag;

    assign fifo_empty = (fifo_cnt == '0);
    assign head_tag   = fifo_tag[rd_ptr];
    assign pop        = !fifo_empty && RdReady_SI[head_tag];
    assign push       = pipe_vld[READ_LATENCY-1];

    // Reset gates issue so nothing is granted while the bank is held in reset.
    assign issue_ok = Reset_RI && ((credit_cnt < DEPTH_C) || (pop && (credit_cnt == DEPTH_C)));

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        arb_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_any && Req_SI[arb_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = PTR_W'(arb_idx);
            end
        end
        if (!issue_ok) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        Gnt_SO = '0;
        if (gnt_any) begin
            Gnt_SO[gnt_idx] = 1'b1;
        end
    end

    assign SramEn_SO   = gnt_any;
    assign SramAddr_DO = gnt_any ? Addr_DI[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;

    always_comb begin
        RdValid_SO = '0;
        if (!fifo_empty) begin
            RdValid_SO[head_tag] = 1'b1;
        end
    end

    assign RdData_DO = fifo_empty ? '0 : fifo_data[rd_ptr];

    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) begin
            rr_ptr     <= '0;
            credit_cnt <= '0;
        end else begin
            if (gnt_any) begin
                rr_ptr <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + PTR_W'(1);
            end
            case ({gnt_any, pop})
                2'b10:   credit_cnt <= credit_cnt + CNT_W'(1);
                2'b01:   credit_cnt <= credit_cnt - CNT_W'(1);
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    // Tag pipeline mirrors the SRAM latency so each returning word knows its owner.
    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) begin
            pipe_vld <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                pipe_tag[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= gnt_any;
            pipe_tag[0] <= gnt_idx;
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_tag[s] <= pipe_tag[s-1];
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (push) begin
            fifo_data[wr_ptr] <= SramData_DI;
            fifo_tag[wr_ptr]  <= pipe_tag[READ_LATENCY-1];
        end
    end

    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef SRAM_ARB_PERF_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        logic [15:0] gnt_cnt;
        logic [15:0] stall_cnt;

        always_ff @(posedge Clk_CI or negedge Reset_RI) begin
            if (!Reset_RI) begin
                gnt_cnt   <= '0;
                stall_cnt <= '0;
            end else begin
                if (Gnt_SO[g] && (gnt_cnt != 16'hFFFF)) begin
                    gnt_cnt <= gnt_cnt + 16'd1;
                end
                if (Req_SI[g] && !Gnt_SO[g] && (stall_cnt != 16'hFFFF)) begin
                    stall_cnt <= stall_cnt + 16'd1;
                end
            end
        end

        assign PerfGnt_DO[g*16 +: 16]   = gnt_cnt;
        assign PerfStall_DO[g*16 +: 16] = stall_cnt;
    end
`endif

endmodule

// File: tb/tb_hv_sram_read_arbiter.sv
// Directed-vector bench for hv_sram_read_arbiter with a READ_LATENCY=1 SRAM model.
// Perf-counter checks are compiled in when SRAM_ARB_PERF_EN is defined.

module tb_hv_sram_read_arbiter;

    localparam int NUM_REQ      = 3;
    localparam int ADDR_WIDTH   = 8;
    localparam int DATA_WIDTH   = 32;
    localparam int READ_LATENCY = 1;

    logic                          Clk_CI = 1'b0;
    logic                          Reset_RI;
    logic [NUM_REQ-1:0]            Req_SI;
    logic [NUM_REQ*ADDR_WIDTH-1:0] Addr_DI;
    logic [NUM_REQ-1:0]            Gnt_SO;
    logic [NUM_REQ-1:0]            RdValid_SO;
    logic [NUM_REQ-1:0]            RdReady_SI;
    logic [DATA_WIDTH-1:0]         RdData_DO;
    logic                          SramEn_SO;
    logic [ADDR_WIDTH-1:0]         SramAddr_DO;
    logic [DATA_WIDTH-1:0]         SramData_DI;
`ifdef SRAM_ARB_PERF_EN
    logic [NUM_REQ*16-1:0]         PerfGnt_DO;
    logic [NUM_REQ*16-1:0]         PerfStall_DO;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [23:0] BASE_ADDRS = {8'd13, 8'd9, 8'd5};

    hv_sram_read_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .Clk_CI      (Clk_CI),
        .Reset_RI    (Reset_RI),
        .Req_SI      (Req_SI),
        .Addr_DI     (Addr_DI),
        .Gnt_SO      (Gnt_SO),
        .RdValid_SO  (RdValid_SO),
        .RdReady_SI  (RdReady_SI),
        .RdData_DO   (RdData_DO),
`ifdef SRAM_ARB_PERF_EN
        .PerfGnt_DO  (PerfGnt_DO),
        .PerfStall_DO(PerfStall_DO),
`endif
        .SramEn_SO   (SramEn_SO),
        .SramAddr_DO (SramAddr_DO),
        .SramData_DI (SramData_DI)
    );

    always #5 Clk_CI = ~Clk_CI;

    function automatic logic [DATA_WIDTH-1:0] sram_word(input logic [ADDR_WIDTH-1:0] a);
        return {24'hC0FFEE, a};
    endfunction

    // One-cycle SRAM: data for the address enabled this cycle appears next cycle.
    always @(posedge Clk_CI) begin
        if (SramEn_SO) begin
            SramData_DI <= sram_word(SramAddr_DO);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] req, input logic [2:0] ready, input logic [23:0] addrs);
        @(posedge Clk_CI);
        #1;
        Req_SI     = req;
        RdReady_SI = ready;
        Addr_DI    = addrs;
    endtask

    task automatic run_cycle(input string name, input logic [2:0] req, input logic [2:0] ready,
                             input logic [23:0] addrs, input logic [2:0] exp_gnt,
                             input logic [7:0] exp_addr, input logic [2:0] exp_vld,
                             input logic [7:0] exp_data_addr);
        applyStimulus(req, ready, addrs);
        @(negedge Clk_CI);
        checkOutput({name, ".gnt"}, 64'(Gnt_SO), 64'(exp_gnt));
        checkOutput({name, ".en"}, 64'(SramEn_SO), 64'(|exp_gnt));
        if (exp_gnt != 3'b000) begin
            checkOutput({name, ".addr"}, 64'(SramAddr_DO), 64'(exp_addr));
        end
        checkOutput({name, ".vld"}, 64'(RdValid_SO), 64'(exp_vld));
        if (exp_vld != 3'b000) begin
            checkOutput({name, ".data"}, 64'(RdData_DO), 64'(sram_word(exp_data_addr)));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checkOutput({name, ".gnt"}, 64'(Gnt_SO), 64'd0);
        checkOutput({name, ".en"}, 64'(SramEn_SO), 64'd0);
        checkOutput({name, ".addr"}, 64'(SramAddr_DO), 64'd0);
        checkOutput({name, ".vld"}, 64'(RdValid_SO), 64'd0);
        checkOutput({name, ".data"}, 64'(RdData_DO), 64'd0);
    endtask

    initial begin
        Reset_RI   = 1'b0;
        Req_SI     = 3'b111;
        RdReady_SI = 3'b111;
        Addr_DI    = BASE_ADDRS;
        SramData_DI = '0;
        repeat (2) @(negedge Clk_CI);
        check_reset_outputs("reset");
        Req_SI   = 3'b000;
        Reset_RI = 1'b1;

        // Round robin over all three requesters, one read per cycle.
        run_cycle("rr0", 3'b111, 3'b111, BASE_ADDRS, 3'b001, 8'd5,  3'b000, 8'd0);
        run_cycle("rr1", 3'b111, 3'b111, BASE_ADDRS, 3'b010, 8'd9,  3'b000, 8'd0);
        run_cycle("rr2", 3'b111, 3'b111, BASE_ADDRS, 3'b100, 8'd13, 3'b001, 8'd5);
        run_cycle("rr3", 3'b111, 3'b111, BASE_ADDRS, 3'b001, 8'd5,  3'b010, 8'd9);
        run_cycle("rr4", 3'b111, 3'b111, BASE_ADDRS, 3'b010, 8'd9,  3'b100, 8'd13);
        run_cycle("rr5", 3'b111, 3'b111, BASE_ADDRS, 3'b100, 8'd13, 3'b001, 8'd5);
        run_cycle("rr6", 3'b000, 3'b111, BASE_ADDRS, 3'b000, 8'd0,  3'b010, 8'd9);
        run_cycle("rr7", 3'b000, 3'b111, BASE_ADDRS, 3'b000, 8'd0,  3'b100, 8'd13);
        run_cycle("rr8", 3'b000, 3'b111, BASE_ADDRS, 3'b000, 8'd0,  3'b000, 8'd0);

        // Lone requester 2 is granted back to back with changing addresses.
        run_cycle("solo0", 3'b100, 3'b111, {8'd20, 8'd9, 8'd5}, 3'b100, 8'd20, 3'b000, 8'd0);
        run_cycle("solo1", 3'b100, 3'b111, {8'd21, 8'd9, 8'd5}, 3'b100, 8'd21, 3'b000, 8'd0);
        run_cycle("solo2", 3'b100, 3'b111, {8'd22, 8'd9, 8'd5}, 3'b100, 8'd22, 3'b100, 8'd20);
        run_cycle("solo3", 3'b100, 3'b111, {8'd23, 8'd9, 8'd5}, 3'b100, 8'd23, 3'b100, 8'd21);
        run_cycle("solo4", 3'b000, 3'b111, BASE_ADDRS, 3'b000, 8'd0, 3'b100, 8'd22);
        run_cycle("solo5", 3'b000, 3'b111, BASE_ADDRS, 3'b000, 8'd0, 3'b100, 8'd23);
        run_cycle("solo6", 3'b000, 3'b111, BASE_ADDRS, 3'b000, 8'd0, 3'b000, 8'd0);

        // No one ready: credit limit of two, then a single pop frees exactly one grant.
        run_cycle("cred0", 3'b111, 3'b000, BASE_ADDRS, 3'b001, 8'd5,  3'b000, 8'd0);
        run_cycle("cred1", 3'b111, 3'b000, BASE_ADDRS, 3'b010, 8'd9,  3'b000, 8'd0);
        run_cycle("cred2", 3'b111, 3'b000, BASE_ADDRS, 3'b000, 8'd0,  3'b001, 8'd5);
        run_cycle("cred3", 3'b111, 3'b000, BASE_ADDRS, 3'b000, 8'd0,  3'b001, 8'd5);
        run_cycle("cred4", 3'b111, 3'b001, BASE_ADDRS, 3'b100, 8'd13, 3'b001, 8'd5);
        run_cycle("cred5", 3'b111, 3'b000, BASE_ADDRS, 3'b000, 8'd0,  3'b010, 8'd9);
        run_cycle("cred6", 3'b111, 3'b000, BASE_ADDRS, 3'b000, 8'd0,  3'b010, 8'd9);

        // Asynchronous reset with reads outstanding.
        @(posedge Clk_CI);
        #3;
        Reset_RI = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge Clk_CI);
        Req_SI     = 3'b000;
        RdReady_SI = 3'b111;
        @(negedge Clk_CI);
        Reset_RI = 1'b1;
        run_cycle("post0", 3'b000, 3'b111, BASE_ADDRS, 3'b000, 8'd0, 3'b000, 8'd0);
        run_cycle("post1", 3'b000, 3'b111, BASE_ADDRS, 3'b000, 8'd0, 3'b000, 8'd0);
        run_cycle("post2", 3'b000, 3'b111, BASE_ADDRS, 3'b000, 8'd0, 3'b000, 8'd0);

        // Stalled head for requester 0 blocks requester 1 behind it.
        run_cycle("hol0", 3'b111, 3'b110, BASE_ADDRS, 3'b001, 8'd5, 3'b000, 8'd0);
        run_cycle("hol1", 3'b111, 3'b110, BASE_ADDRS, 3'b010, 8'd9, 3'b000, 8'd0);
        run_cycle("hol2", 3'b111, 3'b110, BASE_ADDRS, 3'b000, 8'd0, 3'b001, 8'd5);
        run_cycle("hol3", 3'b000, 3'b110, BASE_ADDRS, 3'b000, 8'd0, 3'b001, 8'd5);
        run_cycle("hol4", 3'b000, 3'b110, BASE_ADDRS, 3'b000, 8'd0, 3'b001, 8'd5);
        run_cycle("hol5", 3'b000, 3'b111, BASE_ADDRS, 3'b000, 8'd0, 3'b001, 8'd5);
        run_cycle("hol6", 3'b000, 3'b110, BASE_ADDRS, 3'b000, 8'd0, 3'b010, 8'd9);
        run_cycle("hol7", 3'b000, 3'b110, BASE_ADDRS, 3'b000, 8'd0, 3'b000, 8'd0);

`ifdef SRAM_ARB_PERF_EN
        // Requester 1 contends for ten cycles and wins every third one.
        @(negedge Clk_CI);
        Reset_RI = 1'b0;
        @(negedge Clk_CI);
        Reset_RI = 1'b1;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(3'b111, 3'b111, BASE_ADDRS);
        end
        applyStimulus(3'b000, 3'b111, BASE_ADDRS);
        @(negedge Clk_CI);
        checkOutput("perf.gnt1", 64'(PerfGnt_DO[16 +: 16]), 64'd3);
        checkOutput("perf.stall1", 64'(PerfStall_DO[16 +: 16]), 64'd7);
        checkOutput("perf.gnt0", 64'(PerfGnt_DO[0 +: 16]), 64'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hv_sram_read_arbiter.md
Name: hv_sram_read_arbiter

Overview:
- Shares one single-ported, fixed-latency HV memory bank among NUM_REQ spatial-encoder modality requesters.
- Requesters are the per-modality iM / projM fetch paths.
- Arbitration is round-robin; one read is issued per cycle at most.
- Read data is returned in order through a credit-protected response FIFO, tagged back to the issuing requester, with per-requester ready backpressure.

Parameters:
- NUM_REQ, 3: number of requesters (modalities).
- ADDR_WIDTH, 8: SRAM row address width.
- DATA_WIDTH, `HV_DIMENSION: SRAM row width.
- READ_LATENCY, 1: cycles from SramEn_SO to SramData_DI valid; legal range 1..4.
- RESP_DEPTH, READ_LATENCY+1: response FIFO depth, and the credit limit.

Ports:
- Clk_CI  in  1  clock.
- Reset_RI  in  1  reset.
- Req_SI  in  NUM_REQ  per-requester read request.
- Addr_DI  in  NUM_REQ*ADDR_WIDTH  per-requester address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- Gnt_SO  out  NUM_REQ  one-hot grant; the request is accepted in this cycle.
- RdValid_SO  out  NUM_REQ  one-hot; head of response FIFO belongs to requester i.
- RdReady_SI  in  NUM_REQ  per-requester response accept.
- RdData_DO  out  DATA_WIDTH  response data (head of FIFO).
- SramEn_SO  out  1  SRAM read enable.
- SramAddr_DO  out  ADDR_WIDTH  SRAM read address.
- SramData_DI  in  DATA_WIDTH  SRAM read data, valid READ_LATENCY cycles after SramEn_SO.

Interface decision: one clock (Clk_CI); reset Reset_RI is asynchronous and active-low.

Behaviour:
- Reset (Reset_RI=0, asynchronous):
  - Gnt_SO=0, RdValid_SO=0, SramEn_SO=0, SramAddr_DO=0, RdData_DO=0.
  - RR pointer=0, credit count=0, FIFO empty, in-flight tag pipeline cleared.
- Reset mid-operation: in-flight reads and buffered responses are discarded; nothing is returned after reset deasserts.
- Credit count = reads in flight + entries buffered. Issue is allowed only when count < RESP_DEPTH, or count == RESP_DEPTH-1+pop (a same-cycle pop frees a slot).
- Arbitration (combinational, same cycle):
  - Among the asserted Req_SI bits, grant the first index at or after the RR pointer, wrapping modulo NUM_REQ.
  - If issue is not allowed, Gnt_SO=0.
- On grant to requester i:
  - SramEn_SO=1 and SramAddr_DO=Addr_DI[i] in the same cycle; Gnt_SO is combinational, while SramEn_SO and SramAddr_DO are driven combinationally from the grant.
  - Tag i enters a READ_LATENCY-deep tag shift pipeline.
  - RR pointer <= (i+1) mod NUM_REQ. The pointer is unchanged when nothing is granted.
- Requester protocol:
  - Req and Addr stay stable until Gnt.
  - If Req drops before Gnt, the request is withdrawn; this is legal and nothing is issued for it.
- Return path: when the tag pipeline output is valid, SramData_DI and the tag are pushed into the FIFO. Overflow is impossible by credit.
- Response output:
  - RdValid_SO = onehot(head tag) when the FIFO is non-empty, else 0.
  - RdData_DO = head data.
  - Pop when RdReady_SI[head tag] & RdValid_SO[head tag].
  - Strict in-order delivery: a stalled head blocks responses to other requesters (head-of-line blocking is intended).
- Simultaneous push and pop: FIFO occupancy is unchanged. Simultaneous issue and pop: credit count is unchanged.
- Latency: grant to RdValid is READ_LATENCY+1 cycles when the FIFO is empty (one cycle through the FIFO register).
- Throughput: one read per cycle sustained when all requesters keep RdReady high.
- Wrap-around: FIFO pointers are modulo RESP_DEPTH; the credit counter is ceilLog2(RESP_DEPTH+1) bits wide.

Optional Feature:
- Macro: SRAM_ARB_PERF_EN.
- When defined:
  - Adds output PerfGnt_DO (NUM_REQ*16): per-requester grant counters, 16-bit, saturating at 16'hFFFF.
  - Adds output PerfStall_DO (NUM_REQ*16): per-requester counts of cycles with Req asserted and no Gnt, saturating.
  - Both counter sets are cleared by reset.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- All three Req held high, RdReady all 1, READ_LATENCY=1, addrs 5/9/13 -> grants cycle 0,1,2,0..., SramAddr_DO 5,9,13,...; RdValid one-hot order matches grant order, 2 cycles after each grant.
- Only Req[2] high for 4 cycles -> Gnt[2] every cycle; RR pointer returns to 0 after each grant; data returned in order.
- RdReady all 0 with continuous requests -> exactly RESP_DEPTH grants, then Gnt_SO=0. Raise the head's ready for 1 cycle -> one pop, then exactly one new grant.
- Head tagged requester 0 stalled (RdReady[0]=0, others 1) -> RdValid[1], RdValid[2] never assert until requester 0 accepts; order is preserved.
- Reset asserted while 2 reads are in flight -> all outputs 0 immediately; after release, no RdValid until new grants.
- SRAM_ARB_PERF_EN defined, Req[1] contended for 10 cycles with 3 grants -> PerfGnt[1]=3, PerfStall[1]=7; forced count beyond 16'hFFFF holds at 16'hFFFF.
